// File: rtl/fifo_cdc_pkg.sv
// Shared helpers for the async FIFO pointer blocks (write side and read side).
// Gray/binary conversion at a fixed maximum width; callers zero-extend and truncate.
package fifo_cdc_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended Gray inputs convert correctly because the extra top bits are 0.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic bit params_ok(input int addr_w, input int afull_thresh);
        return (addr_w >= 1) && (addr_w < PTR_MAX_W - 1) &&
               (afull_thresh >= 1) && (afull_thresh <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full / almost-full / level / overflow logic of the async FIFO.
// The synchronized read pointer arrives already through the read->write sync_2ff.
module fifo_wptr_full
    import fifo_cdc_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int AFULL_THRESH = 2**ADDR_W - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_winc,
    input  logic [ADDR_W:0]   p_rptr_gray_sync,
    output logic [ADDR_W-1:0] p_waddr,
    output logic [ADDR_W:0]   p_wptr_gray,
    output logic              p_wfull,
    output logic              p_wafull,
    output logic [ADDR_W:0]   p_wlevel,
    output logic              p_wovf
);

    localparam int PW = ADDR_W + 1;

    if (!params_ok(ADDR_W, AFULL_THRESH)) begin : g_param_err
        $error("fifo_wptr_full: ADDR_W must be >= 1 and AFULL_THRESH in 1..2**ADDR_W");
    end

    localparam logic [ADDR_W:0] AFULL_L   = AFULL_THRESH[ADDR_W:0];
    // Top two Gray bits inverted marks "write pointer one lap ahead"; both bits when ADDR_W=1.
    localparam logic [ADDR_W:0] FULL_MASK = PW'(3) << (ADDR_W - 1);

    logic [ADDR_W:0] bin_q;
    logic [ADDR_W:0] gray_q;
    logic [ADDR_W:0] level_q;
    logic            full_q;
    logic            afull_q;
    logic            ovf_q;

    logic            wr_ok;
    logic [ADDR_W:0] bin_next;
    logic [ADDR_W:0] gray_next;
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] level_next;
    logic            full_next;
    logic            afull_next;

    // The RAM write enable in the FIFO top must be this wr_ok, never raw p_winc.
    always_comb begin
        wr_ok      = p_winc & ~full_q;
        bin_next   = bin_q + PW'(wr_ok);
        gray_next  = PW'(bin2gray(ptr_t'(bin_next)));
        rbin       = PW'(gray2bin(ptr_t'(p_rptr_gray_sync)));
        level_next = bin_next - rbin;
        full_next  = (gray_next == (p_rptr_gray_sync ^ FULL_MASK));
        afull_next = (level_next >= AFULL_L);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bin_q   <= bin_next;
            gray_q  <= gray_next;
            level_q <= level_next;
            full_q  <= full_next;
            afull_q <= afull_next;
            ovf_q   <= p_winc & full_q;
        end
    end

    // Gray pointer goes to the CDC synchronizer straight from its flop.
    assign p_wptr_gray = gray_q;
    assign p_waddr     = bin_q[ADDR_W-1:0];
    assign p_wfull     = full_q;
    assign p_wafull    = afull_q;
    assign p_wlevel    = level_q;
    assign p_wovf      = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ADDR_W=4, AFULL_THRESH=14):
// per-cycle scoreboard from a level-based model plus a hand-filled vector table.
module tb_fifo_wptr_full;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       winc;
    logic [4:0] rg;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic       wfull;
    logic       wafull;
    logic [4:0] wlevel;
    logic       wovf;

    fifo_wptr_full #(.ADDR_W(4), .AFULL_THRESH(14)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .p_winc           (winc),
        .p_rptr_gray_sync (rg),
        .p_waddr          (waddr),
        .p_wptr_gray      (wptr_gray),
        .p_wfull          (wfull),
        .p_wafull         (wafull),
        .p_wlevel         (wlevel),
        .p_wovf           (wovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] waddr;
        logic [4:0] gray;
        logic       full;
        logic       afull;
        logic [4:0] level;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic       winc;
        logic [4:0] rg;
        logic       full;
        logic       afull;
        logic [4:0] level;
        logic       ovf;
        logic [4:0] gray;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[20];

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] m_bin;
    logic       m_full;

    function automatic logic [4:0] tb_b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] tb_g2b(input logic [4:0] g);
        logic [4:0] b;
        for (int i = 0; i < 5; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " waddr"}, 32'(waddr), 0);
        check({tag, " gray"},  32'(wptr_gray), 0);
        check({tag, " full"},  32'(wfull), 0);
        check({tag, " afull"}, 32'(wafull), 0);
        check({tag, " level"}, 32'(wlevel), 0);
        check({tag, " ovf"},   32'(wovf), 0);
    endtask

    // One clock: predict from the model, push, clock, pop and compare.
    task automatic cycle();
        exp_t       e;
        logic       ok;
        logic [4:0] nb;
        logic [4:0] lvl;
        ok      = winc & ~m_full;
        nb      = m_bin + 5'(ok);
        lvl     = nb - tb_g2b(rg);
        e.waddr = nb[3:0];
        e.gray  = tb_b2g(nb);
        e.level = lvl;
        e.full  = (lvl == 5'd16);
        e.afull = (lvl >= 5'd14);
        e.ovf   = winc & m_full;
        sb.push_back(e);
        m_bin  = nb;
        m_full = e.full;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb waddr", 32'(waddr), 32'(e.waddr));
        check("sb gray",  32'(wptr_gray), 32'(e.gray));
        check("sb full",  32'(wfull), 32'(e.full));
        check("sb afull", 32'(wafull), 32'(e.afull));
        check("sb level", 32'(wlevel), 32'(e.level));
        check("sb ovf",   32'(wovf), 32'(e.ovf));
    endtask

    task automatic do_reset(input logic w);
        rst_n = 1'b0;
        winc  = w;
        rg    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n  = 1'b1;
        m_bin  = '0;
        m_full = 1'b0;
    endtask

    initial begin
        logic [4:0] bin_hist[100];
        logic [4:0] prev_gray;
        logic [3:0] prev_waddr;
        logic       saw_addr_wrap;
        logic       saw_bin_wrap;

        // Fill sequence, overflow attempts, then a read-pointer advance.
        for (int k = 0; k < 16; k++) begin
            vecs[k].winc  = 1'b1;
            vecs[k].rg    = 5'd0;
            vecs[k].full  = (k == 15);
            vecs[k].afull = (k + 1 >= 14);
            vecs[k].level = 5'(k + 1);
            vecs[k].ovf   = 1'b0;
            vecs[k].gray  = tb_b2g(5'(k + 1));
        end
        for (int k = 16; k < 19; k++) begin
            vecs[k].winc  = 1'b1;
            vecs[k].rg    = 5'd0;
            vecs[k].full  = 1'b1;
            vecs[k].afull = 1'b1;
            vecs[k].level = 5'd16;
            vecs[k].ovf   = 1'b1;
            vecs[k].gray  = 5'b11000;
        end
        vecs[19].winc  = 1'b0;
        vecs[19].rg    = 5'b00110;
        vecs[19].full  = 1'b0;
        vecs[19].afull = 1'b0;
        vecs[19].level = 5'd12;
        vecs[19].ovf   = 1'b0;
        vecs[19].gray  = 5'b11000;

        // Reset with write held, then first accepted write.
        do_reset(1'b1);
        cycle();
        check("first write waddr", 32'(waddr), 1);
        check("first write gray",  32'(wptr_gray), 32'(5'b00001));

        // Table: 16 writes, 3 overflow attempts, read advance to gray(4).
        do_reset(1'b0);
        for (int k = 0; k < 20; k++) begin
            winc = vecs[k].winc;
            rg   = vecs[k].rg;
            cycle();
            check($sformatf("vec%0d full", k),  32'(wfull),     32'(vecs[k].full));
            check($sformatf("vec%0d afull", k), 32'(wafull),    32'(vecs[k].afull));
            check($sformatf("vec%0d level", k), 32'(wlevel),    32'(vecs[k].level));
            check($sformatf("vec%0d ovf", k),   32'(wovf),      32'(vecs[k].ovf));
            check($sformatf("vec%0d gray", k),  32'(wptr_gray), 32'(vecs[k].gray));
        end

        // 100 writes with the read pointer trailing 3 cycles behind.
        do_reset(1'b0);
        prev_gray     = '0;
        prev_waddr    = '0;
        saw_addr_wrap = 1'b0;
        saw_bin_wrap  = 1'b0;
        winc          = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rg = (i >= 3) ? tb_b2g(bin_hist[i-3]) : 5'd0;
            cycle();
            bin_hist[i] = m_bin;
            check("trail gray one-bit step", $countones(prev_gray ^ wptr_gray), 1);
            check("trail no false full", 32'(wfull), 0);
            if (prev_waddr == 4'd15 && waddr == 4'd0) saw_addr_wrap = 1'b1;
            if (prev_gray == 5'b10000 && wptr_gray == 5'd0) saw_bin_wrap = 1'b1;
            prev_gray  = wptr_gray;
            prev_waddr = waddr;
        end
        check("waddr wrapped 15->0", 32'(saw_addr_wrap), 1);
        check("bin wrapped 31->0",   32'(saw_bin_wrap), 1);

        // Reset mid-stream at level 9: outputs clear without a clock edge.
        do_reset(1'b0);
        winc = 1'b1;
        for (int i = 0; i < 9; i++) cycle();
        check("pre-reset level", 32'(wlevel), 9);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_bin  = '0;
        m_full = 1'b0;
        cycle();
        check("level after re-release", 32'(wlevel), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
